// File: rtl/seg7_scan_drv.sv
// Four-digit multiplexed 7-segment driver: a prescaled scan of hex digits with
// per-frame input capture, leading-zero blanking and registered active-low outputs.
module seg7_scan_drv #(
    parameter int DIV = 50000,
    parameter int PW  = 20
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [15:0]   sh_dig;
    logic [3:0]    sh_dp;
    logic          sh_lz;
    logic          tick, wrap, blank;
    logic [3:0]    nib;

    // A wrap tick already in progress finishes even if en drops on that cycle.
    assign tick = (presc == LAST) && (en || idx == 2'd3);
    assign wrap = tick && (idx == 2'd3);
    assign nib  = sh_dig[{idx, 2'b00} +: 4];

    always_comb begin
        blank = 1'b0;
        if (sh_lz) begin
            case (idx)
                2'd3:    blank = (sh_dig[15:12] == 4'd0);
                2'd2:    blank = (sh_dig[15:8]  == 8'd0);
                2'd1:    blank = (sh_dig[15:4]  == 12'd0);
                default: blank = 1'b0;
            endcase
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc      <= '0;
            idx        <= 2'd0;
            sh_dig     <= 16'h0000;
            sh_dp      <= 4'h0;
            sh_lz      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (tick) begin
                presc <= '0;
                idx   <= idx + 2'd1;
            end else if (en) begin
                presc <= presc + 1'b1;
            end
            if (wrap) begin
                sh_dig <= digits_in;
                sh_dp  <= dp_in;
                sh_lz  <= lz_en;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            an  <= 4'hF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else if (en) begin
            an  <= ~(4'b0001 << idx);
            seg <= blank ? 7'h7F : hex7(nib);
            dp  <= ~sh_dp[idx];
        end else begin
            an  <= 4'hF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Scoreboard bench for seg7_scan_drv: a frame-position model pushes expected
// outputs on each clock, a monitor pops and compares on the falling edge.
module tb_seg7_scan_drv;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic [15:0] digits_in = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic        lz_en = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t q[$];

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan_drv #(.DIV(DIV), .PW(3)) dut (
        .clk(clk), .rstn(rstn), .en(en), .digits_in(digits_in), .dp_in(dp_in),
        .lz_en(lz_en), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model tracks position within the frame in enabled clocks, not prescaler/index.
    initial begin
        int pos;
        logic [15:0] m_dig;
        logic [3:0]  m_dp;
        logic        m_lz;
        pos = 0; m_dig = 0; m_dp = 0; m_lz = 0;
        forever begin
            @(posedge clk);
            if (!rstn) begin
                pos = 0; m_dig = 0; m_dp = 0; m_lz = 0;
            end else begin
                int   slot;
                logic wrap, blank;
                exp_t e;
                slot  = pos / DIV;
                wrap  = (pos == FRAME - 1);
                blank = m_lz && slot > 0 && ((m_dig >> (4 * slot)) == 16'd0);
                e.an  = en ? ~(4'b0001 << slot) : 4'hF;
                e.seg = (!en || blank) ? 7'h7F : seg_tab[(m_dig >> (4 * slot)) & 16'hF];
                e.dp  = en ? ~m_dp[slot] : 1'b1;
                e.fd  = wrap;
                if (en || wrap) begin
                    if (wrap) begin
                        m_dig = digits_in; m_dp = dp_in; m_lz = lz_en;
                    end
                    pos = (pos + 1) % FRAME;
                end
                q.push_back(e);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rstn && q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("an", 32'(an), 32'(e.an));
                chk("seg", 32'(seg), 32'(e.seg));
                chk("dp", 32'(dp), 32'(e.dp));
                chk("frame_done", 32'(frame_done), 32'(e.fd));
            end
        end
    end

    task automatic drive(input int n, input logic e, input logic [15:0] d,
                         input logic [3:0] p, input logic lz);
        repeat (n) begin
            @(negedge clk);
            en = e; digits_in = d; dp_in = p; lz_en = lz;
        end
    endtask

    function automatic logic [15:0] rnd_digits();
        logic [15:0] v;
        v = 16'($urandom);
        for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 2) == 0) v[4*i +: 4] = 4'h0;
        return v;
    endfunction

    task automatic rnd_phase(input int n);
        logic [15:0] d;
        logic [3:0]  p;
        logic        lz;
        d = rnd_digits(); p = 4'($urandom); lz = 1'($urandom);
        for (int i = 0; i < n; i++) begin
            if (i % 3 == 0) begin
                d = rnd_digits(); p = 4'($urandom); lz = 1'($urandom);
            end
            drive(1, $urandom_range(0, 7) != 0, d, p, lz);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_an"}, 32'(an), 32'hF);
        chk({tag, "_seg"}, 32'(seg), 32'h7F);
        chk({tag, "_dp"}, 32'(dp), 32'h1);
        chk({tag, "_fd"}, 32'(frame_done), 32'h0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 check_reset_vals("rst");
        @(negedge clk); #1 rstn = 1'b1;

        drive(40, 1'b1, 16'h1234, 4'h0, 1'b0);
        drive(40, 1'b1, 16'h0050, 4'b0101, 1'b1);
        drive(40, 1'b1, 16'h0000, 4'b0101, 1'b1);
        drive(6, 1'b1, 16'h00A7, 4'b0000, 1'b0);
        drive(10, 1'b0, 16'h00A7, 4'b0000, 1'b0);
        drive(40, 1'b1, 16'h00A7, 4'b0000, 1'b0);
        rnd_phase(400);

        // Asynchronous reset between clock edges, mid-frame.
        drive(5, 1'b1, 16'h9876, 4'hF, 1'b0);
        @(posedge clk); #2;
        rstn = 1'b0;
        q.delete();
        #1 check_reset_vals("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk); #1 rstn = 1'b1;
        drive(40, 1'b1, 16'h0C0D, 4'b1000, 1'b1);
        rnd_phase(300);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seg7_scan_drv.md
SEG7_SCAN_DRV -- requirements
Module: seg7_scan_drv

Interface
REQ-001: Parameter DIV, default 50000: clocks per digit slot; legal range 2..2^20.
REQ-002: Parameter PW, default 20: prescaler width; SHALL satisfy 2^PW >= DIV.
REQ-003: clk  input  1  single system clock; all state on rising edge.
REQ-004: rstn  input  1  reset; asynchronous, active-low.
REQ-005: en  input  1  display enable; 0 blanks all anodes and freezes scan.
REQ-006: digits_in  input  16  four hex digits from counter blocks; [3:0]=digit0 (rightmost) .. [15:12]=digit3.
REQ-007: dp_in  input  4  decimal point request per digit, bit i = digit i, 1=lit.
REQ-008: lz_en  input  1  1 enables leading-zero blanking.
REQ-009: an  output  4  anode select, active-low, bit i = digit i.
REQ-010: seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011: dp  output  1  decimal point, active-low.
REQ-012: frame_done  output  1  one-clock pulse when a new frame is latched.

Function
REQ-013: Prescaler SHALL count 0..DIV-1 while en=1, wrap to 0, and assert internal tick for the one cycle it equals DIV-1.
REQ-014: Digit index (2 bits) SHALL advance 0->1->2->3->0 on each tick; no other transitions.
REQ-015: While en=0, prescaler and index SHALL hold their values; on en returning to 1, counting resumes from the held values.
REQ-016: On the tick where index wraps 3->0, digits_in, dp_in and lz_en SHALL be captured into shadow registers, and frame_done SHALL pulse high for exactly that cycle.
REQ-017: Inputs SHALL affect outputs only through the shadow registers; input changes mid-frame SHALL NOT alter the frame on display.
REQ-018: an, seg, dp SHALL be registered outputs reflecting (index, shadow, en) with exactly one clock of latency.
REQ-019: Exactly one an bit SHALL be low when en=1 (an[index]=0); an SHALL be 4'b1111 when en=0.
REQ-020: seg SHALL decode the selected shadow nibble as hex 0..F -> 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).
REQ-021: With shadow lz_en=1: digit3 blanked if zero; digit2 blanked if digits 3,2 both zero; digit1 blanked if digits 3..1 all zero; digit0 never blanked.
REQ-022: A blanked digit SHALL drive seg=7F while its anode stays low; dp for that slot still follows shadow dp bit.
REQ-023: dp SHALL be ~shadow_dp[index] when en=1, and 1 when en=0.
REQ-024: When en=0, seg SHALL be 7F.
REQ-025: If en falls on the same cycle as a wrap tick, the tick SHALL complete (index wraps, latch and frame_done occur) and subsequent ticks are frozen.

Reset
REQ-026: rstn=0 SHALL immediately (asynchronously) set prescaler=0, index=0, shadow digits=0, shadow dp=0, shadow lz_en=0, an=4'b1111, seg=7F, dp=1, frame_done=0.
REQ-027: After rstn deassertion, first output update SHALL occur on the first clock edge with en=1; first latch occurs after 4*DIV enabled clocks.
REQ-028: Reset asserted mid-frame SHALL discard the frame in progress; no frame_done pulse SHALL be generated by reset.

Verification (DIV=4)
REQ-029: Reset, en=1, digits_in=16'h1234 -> an cycles 1110,1101,1011,0111 each held 4 clocks; frame_done after 16 clocks; next frame seg = 4->19, 3->30, 2->24, 1->79.
REQ-030: digits_in=16'h0050, lz_en=1 latched -> digit3 and digit2 seg=7F, digit1 seg=12, digit0 seg=40; digits_in=16'h0000 -> only digit0 lit with 40.
REQ-031: Change digits_in every 3 clocks mid-frame -> displayed frame equals value sampled at wrap tick only; frame_done period exactly 16 clocks.
REQ-032: en=0 for 10 clocks mid-frame -> an=1111, seg=7F, dp=1 one clock after en falls; index and prescaler resume unchanged; frame_done delayed by exactly 10 clocks.
REQ-033: dp_in=4'b0101 -> dp=0 on digit0 and digit2 slots only, including a blanked slot with lz_en=1.
REQ-034: rstn pulsed low asynchronously between clock edges mid-frame -> outputs reach reset values without a clock edge; no frame_done; scan restarts at index 0.
